// File: rtl/sdram_arbiter.sv
// Single-outstanding SDRAM arbiter: one download writer (absolute priority) and
// three round-robin readers share one controller port; responses are forwarded to the owner.
module sdram_arbiter #(
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  input  logic                  rd_req_0,
  input  logic                  rd_req_1,
  input  logic                  rd_req_2,
  input  logic [ADDR_WIDTH-1:0] rd_addr_0,
  input  logic [ADDR_WIDTH-1:0] rd_addr_1,
  input  logic [ADDR_WIDTH-1:0] rd_addr_2,
  output logic                  rd_ack_0,
  output logic                  rd_ack_1,
  output logic                  rd_ack_2,
  output logic                  rd_valid_0,
  output logic                  rd_valid_1,
  output logic                  rd_valid_2,
  output logic [DATA_WIDTH-1:0] rd_q,
  output logic [ADDR_WIDTH-1:0] sdram_addr,
  output logic [DATA_WIDTH-1:0] sdram_data,
  output logic                  sdram_we,
  output logic                  sdram_req,
  input  logic                  sdram_ack,
  input  logic                  sdram_valid,
  input  logic [DATA_WIDTH-1:0] sdram_q
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  typedef enum logic [1:0] {OWN_RD0, OWN_RD1, OWN_RD2, OWN_WR} owner_t;

  state_t                r_state;
  state_t                w_state_nxt;
  owner_t                r_owner;
  logic [1:0]            r_last;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_we;

  logic [2:0]            w_rd_req;
  logic                  w_rr_vld;
  logic [1:0]            w_rr_pick;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic                  w_ack_hit;
  logic                  w_val_hit;

  function automatic logic [1:0] rr_idx(input logic [1:0] last, input int unsigned k);
    int unsigned s;
    s = (32'(last) + k) % 3;
    return 2'(s);
  endfunction

  assign w_rd_req = {rd_req_2, rd_req_1, rd_req_0};

  // Search starts one past the last granted reader, wrapping modulo 3.
  always_comb begin
    w_rr_vld  = 1'b0;
    w_rr_pick = r_last;
    for (int unsigned k = 1; k <= 3; k++) begin
      if (!w_rr_vld && w_rd_req[rr_idx(r_last, k)]) begin
        w_rr_vld  = 1'b1;
        w_rr_pick = rr_idx(r_last, k);
      end
    end
  end

  always_comb begin
    case (w_rr_pick)
      2'd0:    w_rd_addr = rd_addr_0;
      2'd1:    w_rd_addr = rd_addr_1;
      default: w_rd_addr = rd_addr_2;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack_hit   = (r_state == S_REQ) && sdram_ack;
    // Valid counts in WAIT, or in REQ together with the ack; never for a write.
    w_val_hit   = (r_owner != OWN_WR) && sdram_valid && ((r_state == S_WAIT) || w_ack_hit);
    wr_ack      = w_ack_hit && (r_owner == OWN_WR);
    rd_ack_0    = w_ack_hit && (r_owner == OWN_RD0);
    rd_ack_1    = w_ack_hit && (r_owner == OWN_RD1);
    rd_ack_2    = w_ack_hit && (r_owner == OWN_RD2);
    rd_valid_0  = w_val_hit && (r_owner == OWN_RD0);
    rd_valid_1  = w_val_hit && (r_owner == OWN_RD1);
    rd_valid_2  = w_val_hit && (r_owner == OWN_RD2);
    rd_q        = sdram_q;
    sdram_req   = (r_state == S_REQ);
    sdram_addr  = r_addr;
    sdram_data  = r_data;
    sdram_we    = r_we;
    case (r_state)
      S_IDLE: if (wr_req || w_rr_vld) w_state_nxt = S_REQ;
      S_REQ:  if (sdram_ack) w_state_nxt = ((r_owner == OWN_WR) || sdram_valid) ? S_IDLE : S_WAIT;
      S_WAIT: if (sdram_valid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_owner <= OWN_RD0;
      r_last  <= 2'd2;
      r_addr  <= '0;
      r_data  <= '0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) begin
        if (wr_req) begin
          r_owner <= OWN_WR;
          r_addr  <= wr_addr;
          r_data  <= wr_data;
          r_we    <= 1'b1;
        end else if (w_rr_vld) begin
          r_owner <= owner_t'(w_rr_pick);
          r_last  <= w_rr_pick;
          r_addr  <= w_rd_addr;
          r_we    <= 1'b0;
        end
      end else if (w_ack_hit && (r_owner == OWN_WR)) begin
        r_we <= 1'b0;
      end
    end
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 23, SDRAM word address width.
REQ-002 Parameter DATA_WIDTH, default 32, SDRAM data width.
REQ-003 Port clk  in  1  system clock; all logic on its rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port wr_req  in  1  download writer request; held high until wr_ack.
REQ-006 Port wr_addr  in  ADDR_WIDTH  download write address.
REQ-007 Port wr_data  in  DATA_WIDTH  download write data.
REQ-008 Port wr_ack  out  1  one-cycle pulse; download write accepted by SDRAM.
REQ-009 Ports rd_req_0..rd_req_2  in  1 each  reader requests (0 = CPU ROM, 1 = tile ROM, 2 = sprite ROM); held high until the matching ack.
REQ-010 Ports rd_addr_0..rd_addr_2  in  ADDR_WIDTH each  reader addresses.
REQ-011 Ports rd_ack_0..rd_ack_2  out  1 each  one-cycle pulse; read accepted.
REQ-012 Ports rd_valid_0..rd_valid_2  out  1 each  one-cycle pulse; rd_q holds read data.
REQ-013 Port rd_q  out  DATA_WIDTH  shared read data, meaningful only with a rd_valid_n pulse.
REQ-014 Ports sdram_addr (ADDR_WIDTH), sdram_data (DATA_WIDTH), sdram_we (1), sdram_req (1)  out  controller request side.
REQ-015 Ports sdram_ack (1), sdram_valid (1), sdram_q (DATA_WIDTH)  in  controller response side.

Function
REQ-016 FSM states IDLE, REQ, WAIT; exactly one SDRAM transaction outstanding at any time.
REQ-017 IDLE: with any request pending, the arbiter latches owner, address, data and direction into registers and moves to REQ on the next edge.
REQ-018 Priority: wr_req absolutely over readers; among readers, round-robin starting at (last_reader + 1) mod 3.
REQ-019 last_reader updates only on reader grant; writer grants leave it unchanged.
REQ-020 REQ: sdram_req = 1 with registered addr/data/we; asserted the cycle after the grant decision (1-cycle request latency).
REQ-021 REQ: sdram_req stays high until sdram_ack; ack forwarded combinationally to owner only (wr_ack or rd_ack_n in the same cycle as sdram_ack).
REQ-022 REQ, write owner: on sdram_ack return to IDLE; no valid expected.
REQ-023 REQ, read owner: on sdram_ack move to WAIT; sdram_req low from the next cycle.
REQ-024 WAIT: sdram_valid forwarded combinationally to rd_valid of the owner; rd_q = sdram_q; return to IDLE on sdram_valid.
REQ-025 sdram_valid arriving in REQ in the same cycle as sdram_ack: forwarded to owner, FSM returns directly to IDLE.
REQ-026 sdram_ack/sdram_valid in IDLE, or valid during a write: ignored, no output pulse.
REQ-027 Requester dropping req after grant: transaction completes, ack/valid still pulsed to that port.
REQ-028 Requests arriving while busy wait; minimum one IDLE cycle between transactions.
REQ-029 rd_q is combinational from sdram_q; no data registering inside the arbiter.
REQ-030 sdram_we = 1 only for writer-owned transactions; sdram_data don't-care on reads.

Reset
REQ-031 On reset: state IDLE; sdram_req, sdram_we = 0; sdram_addr, sdram_data = 0; last_reader = 2 (reader 0 first); all ack/valid outputs 0.
REQ-032 Reset mid-transaction: abandons it immediately; later controller responses land in IDLE and are ignored per REQ-026.

Verification
REQ-033 Single read: rd_req_1, addr 0x000100; ack at cycle 3, valid at cycle 6 with q 0xDEADBEEF -> sdram_req high cycles 1-3, rd_ack_1 pulse at 3, rd_valid_1 + rd_q 0xDEADBEEF at 6, no other port pulses.
REQ-034 Write priority: wr_req and rd_req_0..2 high simultaneously -> first grant to writer with sdram_we = 1, wr_addr/wr_data on bus; readers then served 0,1,2.
REQ-035 Round-robin fairness: all three readers held high for 9 transactions -> grant order 0,1,2,0,1,2,0,1,2; each reader receives 3 valid pulses.
REQ-036 Ack+valid same cycle on a read -> single rd_ack and rd_valid pulse in that cycle, FSM in IDLE next cycle.
REQ-037 Reset asserted in WAIT, valid arrives 2 cycles after reset release -> no rd_valid pulse; next rd_req_0 granted normally.
REQ-038 Spurious sdram_valid in IDLE with no requests -> all rd_valid outputs stay 0, sdram_req stays 0.
